// File: rtl/pipe_addsub.sv
// Pipelined signed add/subtract with carry/overflow/zero flags.
// The carry chain is cut into STAGES equal chunks, one per register stage, under a global enable.
module pipe_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned DIV   = (STAGES == 0) ? 1 : STAGES;
  localparam int unsigned CHUNK = WIDTH / DIV;

  if ((STAGES < 1) || ((WIDTH % DIV) != 0)) begin : g_bad_cfg
    $error("pipe_addsub: STAGES must be >= 1 and divide WIDTH");
  end

  // The whole pipe advances together; a full output register that is not taken freezes everything.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int unsigned LO = CHUNK * k;

    logic             v_i, c_i, v_q, c_q;
    logic [WIDTH-1:0] a_i, bb_i, s_i, s_n, s_q;
    logic [CHUNK:0]   ch;

    if (k == 0) begin : g_head
      assign v_i  = in_valid;
      assign a_i  = a;
      assign bb_i = sub ? ~b : b;
      assign c_i  = sub ^ cin;
      assign s_i  = '0;
    end else begin : g_link
      assign v_i  = g_stg[k-1].v_q;
      assign c_i  = g_stg[k-1].c_q;
      assign s_i  = g_stg[k-1].s_q;
      assign a_i  = g_stg[k-1].g_fwd.a_q;
      assign bb_i = g_stg[k-1].g_fwd.bb_q;
    end

    assign ch = {1'b0, CHUNK'(a_i >> LO)} + {1'b0, CHUNK'(bb_i >> LO)} + (CHUNK+1)'(c_i);

    // Lower chunks already done ride along; this stage fills in its own chunk.
    always_comb begin
      s_n              = s_i;
      s_n[LO +: CHUNK] = ch[CHUNK-1:0];
    end

    // Data only updates on a real op so the output fields hold across bubbles.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_i;
        if (v_i) begin
          c_q <= ch[CHUNK];
          s_q <= s_n;
        end
      end
    end

    if (k + 1 < STAGES) begin : g_fwd
      logic [WIDTH-1:0] a_q, bb_q;
      always_ff @(posedge clk) begin
        if (adv && v_i) begin
          a_q  <= a_i;
          bb_q <= bb_i;
        end
      end
    end else begin : g_out
      logic ovf_q, zero_q;
      // Carry into the MSB is recovered from the MSB operand and result bits.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv && v_i) begin
          ovf_q  <= (a_i[WIDTH-1] ^ bb_i[WIDTH-1] ^ s_n[WIDTH-1]) ^ ch[CHUNK];
          zero_q <= (s_n == '0);
        end
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum       = g_stg[STAGES-1].s_q;
  assign cout      = g_stg[STAGES-1].c_q;
  assign ovf       = g_stg[STAGES-1].g_out.ovf_q;
  assign zero      = g_stg[STAGES-1].g_out.zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: three depths (1, 2, 8) share one stimulus stream,
// each checked by a per-instance scoreboard fed from a plain-arithmetic model.
module tb_pipe_addsub;

  localparam int unsigned W = 8;
  localparam int NDUT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, sub, cin, out_ready;
  logic [W-1:0] a, b;

  logic         in_ready_v  [NDUT];
  logic         out_valid_v [NDUT];
  logic         cout_v      [NDUT];
  logic         ovf_v       [NDUT];
  logic         zero_v      [NDUT];
  logic [W-1:0] sum_v       [NDUT];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready_v[g]),
      .sub      (sub),
      .cin      (cin),
      .a        (a),
      .b        (b),
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready),
      .sum      (sum_v[g]),
      .cout     (cout_v[g]),
      .ovf      (ovf_v[g]),
      .zero     (zero_v[g])
    );
  end

  function automatic int stg(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 2 : 8);
  endfunction

  // Expected {sum, cout, ovf, zero} from integer arithmetic on the operands.
  function automatic logic [10:0] model(input logic s, input logic c,
                                        input logic [7:0] x, input logic [7:0] y);
    int ux, uy, sx, sy, ur, sr;
    logic [7:0] r8;
    logic co, ov;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      ur = ux + uy + int'(c);
      sr = sx + sy + int'(c);
      co = (ur > 255);
    end else begin
      ur = ux - uy - int'(c);
      sr = sx - sy - int'(c);
      co = (ur >= 0);
    end
    r8 = 8'(ur);
    ov = (sr > 127) || (sr < -128);
    return {r8, co, ov, (r8 == 8'h00)};
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d (stages=%0d) t=%0t: got %h want %h", nm, g, stg(g), $time, act, req);
    end
  endtask

  // Scoreboard state
  logic [10:0] exp_mem [NDUT][1024];
  int          acc_mem [NDUT][1024];
  int          wr [NDUT];
  int          rd [NDUT];
  logic        stall_prev [NDUT];
  logic [10:0] held [NDUT];
  int          cyc = 0;
  int          last_nready = -1;
  logic        was_rst = 1'b0;

  initial begin
    for (int g = 0; g < NDUT; g++) begin
      wr[g] = 0;
      rd[g] = 0;
      stall_prev[g] = 1'b0;
      held[g] = '0;
    end
  end

  // Compare process: runs on the falling edge, predicting the handshakes of the next rising edge.
  always @(negedge clk) begin
    logic [10:0] f;
    cyc++;
    if (rst) begin
      for (int g = 0; g < NDUT; g++) begin
        rd[g] = wr[g];
        stall_prev[g] = 1'b0;
      end
      was_rst = 1'b1;
    end else begin
      for (int g = 0; g < NDUT; g++) begin
        f = {sum_v[g], cout_v[g], ovf_v[g], zero_v[g]};
        if (was_rst) chk("reset_state", g, {20'h0, out_valid_v[g], f}, 32'h0);
        chk("in_ready", g, 32'(in_ready_v[g]), 32'(!out_valid_v[g] || out_ready));
        if (stall_prev[g]) chk("stall_hold", g, {20'h0, out_valid_v[g], f}, {20'h0, 1'b1, held[g]});
        if (out_valid_v[g]) begin
          chk("pending", g, 32'(wr[g] > rd[g]), 32'd1);
          if (out_ready && (wr[g] > rd[g])) begin
            chk("result", g, 32'(f), 32'(exp_mem[g][rd[g] % 1024]));
            if (!stall_prev[g] && (last_nready < acc_mem[g][rd[g] % 1024]))
              chk("latency", g, 32'(cyc - acc_mem[g][rd[g] % 1024]), 32'(stg(g)));
            rd[g]++;
          end
        end
        if (in_valid && in_ready_v[g]) begin
          exp_mem[g][wr[g] % 1024] = model(sub, cin, a, b);
          acc_mem[g][wr[g] % 1024] = cyc;
          wr[g]++;
        end
        stall_prev[g] = out_valid_v[g] && !out_ready;
        held[g] = f;
      end
      was_rst = 1'b0;
      if (!out_ready) last_nready = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic c, input logic [7:0] x, input logic [7:0] y);
    sub = s;
    cin = c;
    a   = x;
    b   = y;
  endtask

  // Present one op until the two-stage instance takes it.
  task automatic issue(input logic s, input logic c, input logic [7:0] x, input logic [7:0] y);
    logic ok;
    int guard;
    guard = 0;
    in_valid = 1'b1;
    drive(s, c, x, y);
    forever begin
      @(negedge clk);
      ok = in_ready_v[1];
      tick();
      if (ok) break;
      guard++;
      if (guard > 100) begin
        chk("issue_timeout", 1, 32'(guard), 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Hand-computed values pinning the model
    chk("model_t1",  0, 32'(model(1'b0, 1'b0, 8'h7F, 8'h01)), 32'({8'h80, 1'b0, 1'b1, 1'b0}));
    chk("model_t2a", 0, 32'(model(1'b1, 1'b0, 8'h00, 8'h01)), 32'({8'hFF, 1'b0, 1'b0, 1'b0}));
    chk("model_t2b", 0, 32'(model(1'b1, 1'b1, 8'h05, 8'h03)), 32'({8'h01, 1'b1, 1'b0, 1'b0}));
    chk("model_t3a", 0, 32'(model(1'b0, 1'b0, 8'h80, 8'h80)), 32'({8'h00, 1'b1, 1'b1, 1'b1}));
    chk("model_t3b", 0, 32'(model(1'b0, 1'b0, 8'h0F, 8'h01)), 32'({8'h10, 1'b0, 1'b0, 1'b0}));

    // 0x7F + 0x01 through each depth, checked against literal values and exact latency
    issue(1'b0, 1'b0, 8'h7F, 8'h01);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        if (n < stg(g)) chk("t1_early", g, 32'(out_valid_v[g]), 32'd0);
        if (n == stg(g)) begin
          chk("t1_valid", g, 32'(out_valid_v[g]), 32'd1);
          chk("t1_fields", g, 32'({sum_v[g], cout_v[g], ovf_v[g], zero_v[g]}),
              32'({8'h80, 1'b0, 1'b1, 1'b0}));
        end
      end
    end
    tick();

    issue(1'b1, 1'b0, 8'h00, 8'h01);
    issue(1'b1, 1'b1, 8'h05, 8'h03);
    issue(1'b0, 1'b0, 8'h80, 8'h80);
    issue(1'b0, 1'b0, 8'h0F, 8'h01);
    repeat (10) tick();

    // Four back-to-back ops at full rate
    issue(1'b0, 1'b1, 8'hFF, 8'h00);
    issue(1'b1, 1'b0, 8'h80, 8'h01);
    issue(1'b0, 1'b0, 8'h3C, 8'hC4);
    issue(1'b1, 1'b1, 8'h7F, 8'hFF);
    repeat (10) tick();

    // Stall with the consumer away for three cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(1'b0, 1'b0, 8'h12, 8'h34);
    tick();
    drive(1'b1, 1'b0, 8'h56, 8'h78);
    tick();
    drive(1'b0, 1'b1, 8'h9A, 8'hBC);
    @(negedge clk);
    chk("t5_full", 1, 32'(in_ready_v[1]), 32'd0);
    tick();
    out_ready = 1'b1;
    issue(1'b0, 1'b1, 8'h9A, 8'hBC);
    repeat (12) tick();

    // Reset with ops in flight; nothing from before it may appear afterwards
    in_valid = 1'b1;
    drive(1'b0, 1'b0, 8'h11, 8'h22);
    tick();
    drive(1'b1, 1'b1, 8'h33, 8'h44);
    tick();
    rst = 1'b1;
    drive(1'b0, 1'b0, 8'h55, 8'h66);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) chk("t6_flushed", g, 32'(out_valid_v[g]), 32'd0);
    repeat (12) tick();

    // Random traffic with random back-pressure and occasional reset
    for (int i = 0; i < 2500; i++) begin
      in_valid  = ($urandom % 4) != 0;
      drive(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
      out_ready = ($urandom % 10) < 7;
      rst       = ($urandom % 400) == 0;
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) chk("drained", g, 32'(wr[g] - rd[g]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
